// File: rtl/bp_bpred_trace_buffer.sv
// Branch-predictor update recorder: per-channel staging, round-robin arbiter,
// timestamped trace FIFO drained by a valid/yumi consumer, plus saturating
// update / mispredict / drop statistics.
module bp_bpred_trace_buffer #(
    parameter int bht_idx_width_p = 9,
    parameter int num_ch_p        = 2,
    parameter int depth_p         = 16,
    parameter int ts_width_p      = 16,
    parameter int cnt_width_p     = 32,
    localparam int ch_w           = (num_ch_p > 1) ? $clog2(num_ch_p) : 1,
    localparam int entry_w        = ts_width_p + ch_w + bht_idx_width_p + 1
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [1:0]                          mode_i,
    input  logic                                clear_i,
    input  logic [num_ch_p-1:0]                 w_v_i,
    input  logic [num_ch_p*bht_idx_width_p-1:0] idx_w_i,
    input  logic [num_ch_p-1:0]                 correct_i,
    output logic                                trace_v_o,
    output logic [entry_w-1:0]                  trace_data_o,
    input  logic                                trace_yumi_i,
    output logic [cnt_width_p-1:0]              update_cnt_o,
    output logic [cnt_width_p-1:0]              mispred_cnt_o,
    output logic [cnt_width_p-1:0]              drop_cnt_o,
    output logic                                full_o
);

    localparam int ptr_w = $clog2(depth_p);

    logic [ts_width_p-1:0]                          ts_q;
    logic [cnt_width_p-1:0]                         upd_q, mis_q, drop_q;
    logic [num_ch_p-1:0]                            stg_v_q;
    logic [num_ch_p-1:0][ts_width_p-1:0]            stg_ts_q;
    logic [num_ch_p-1:0][bht_idx_width_p-1:0]       stg_idx_q;
    logic [num_ch_p-1:0]                            stg_corr_q;
    logic [ch_w-1:0]                                rr_q;
    logic [ptr_w-1:0]                               wr_q, rd_q;
    logic [ptr_w:0]                                 cnt_q;
    logic [entry_w-1:0]                             mem_q [depth_p];

    logic                  fifo_v, fifo_full, pop, gnt_ok, gnt_any;
    logic [num_ch_p-1:0]   gnt_vec, elig, load, drop;
    logic [ch_w-1:0]       gnt_id, rr_d;
    logic [entry_w-1:0]    push_entry;
    logic [ch_w:0]         upd_pop, mis_pop, drop_pop;
    int                    c;

    function automatic logic [cnt_width_p-1:0] sat_add(input logic [cnt_width_p-1:0] a,
                                                       input logic [ch_w:0] b);
        logic [cnt_width_p:0] s;
        s = {1'b0, a} + (cnt_width_p+1)'(b);
        return s[cnt_width_p] ? '1 : s[cnt_width_p-1:0];
    endfunction

    assign fifo_v    = (cnt_q != '0);
    assign fifo_full = (cnt_q == (ptr_w+1)'(depth_p));
    assign pop       = trace_yumi_i && fifo_v;
    // A full FIFO may still accept a push when the head is popped the same cycle.
    assign gnt_ok    = !fifo_full || pop;

    // Round-robin grant starting at rr_q over occupied staging registers.
    always_comb begin
        gnt_vec    = '0;
        gnt_any    = 1'b0;
        gnt_id     = '0;
        push_entry = '0;
        c          = 0;
        for (int i = 0; i < num_ch_p; i++) begin
            c = int'(rr_q) + i;
            if (c >= num_ch_p) c = c - num_ch_p;
            if (!gnt_any && gnt_ok && stg_v_q[c]) begin
                gnt_any    = 1'b1;
                gnt_id     = ch_w'(c);
                gnt_vec[c] = 1'b1;
                push_entry = {stg_ts_q[c], ch_w'(c), stg_idx_q[c], stg_corr_q[c]};
            end
        end
        rr_d = rr_q;
        if (gnt_any) rr_d = (gnt_id == ch_w'(num_ch_p - 1)) ? '0 : gnt_id + ch_w'(1);
    end

    // Capture eligibility, staging load/drop decisions and per-cycle popcounts.
    always_comb begin
        upd_pop  = '0;
        mis_pop  = '0;
        drop_pop = '0;
        elig     = '0;
        load     = '0;
        drop     = '0;
        for (int i = 0; i < num_ch_p; i++) begin
            elig[i] = w_v_i[i] && ((mode_i == 2'd1) || ((mode_i == 2'd2) && !correct_i[i]));
            load[i] = elig[i] && (!stg_v_q[i] || gnt_vec[i]);
            drop[i] = elig[i] && stg_v_q[i] && !gnt_vec[i];
            upd_pop  = upd_pop  + (ch_w+1)'(w_v_i[i]);
            mis_pop  = mis_pop  + (ch_w+1)'(w_v_i[i] && !correct_i[i]);
            drop_pop = drop_pop + (ch_w+1)'(drop[i]);
        end
    end

    // Control state: timestamp, counters, staging, arbiter pointer, FIFO pointers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ts_q       <= '0;
            upd_q      <= '0;
            mis_q      <= '0;
            drop_q     <= '0;
            stg_v_q    <= '0;
            stg_ts_q   <= '0;
            stg_idx_q  <= '0;
            stg_corr_q <= '0;
            rr_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else if (clear_i) begin
            ts_q    <= '0;
            upd_q   <= '0;
            mis_q   <= '0;
            drop_q  <= '0;
            stg_v_q <= '0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ts_q <= ts_q + ts_width_p'(1);
            if (mode_i != 2'd0) begin
                upd_q <= sat_add(upd_q, upd_pop);
                mis_q <= sat_add(mis_q, mis_pop);
            end
            drop_q <= sat_add(drop_q, drop_pop);
            for (int i = 0; i < num_ch_p; i++) begin
                if (load[i]) begin
                    stg_v_q[i]    <= 1'b1;
                    stg_ts_q[i]   <= ts_q;
                    stg_idx_q[i]  <= idx_w_i[i*bht_idx_width_p +: bht_idx_width_p];
                    stg_corr_q[i] <= correct_i[i];
                end else if (gnt_vec[i]) begin
                    stg_v_q[i] <= 1'b0;
                end
            end
            rr_q  <= rr_d;
            if (gnt_any) wr_q <= wr_q + ptr_w'(1);
            if (pop)     rd_q <= rd_q + ptr_w'(1);
            cnt_q <= cnt_q + (ptr_w+1)'(gnt_any) - (ptr_w+1)'(pop);
        end
    end

    // Trace storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk_i) begin
        if (gnt_any && !clear_i) mem_q[wr_q] <= push_entry;
    end

    assign trace_v_o     = fifo_v;
    assign trace_data_o  = fifo_v ? mem_q[rd_q] : '0;
    assign full_o        = fifo_full;
    assign update_cnt_o  = upd_q;
    assign mispred_cnt_o = mis_q;
    assign drop_cnt_o    = drop_q;

    // Popping an empty FIFO is a consumer protocol error.
    yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                      !(trace_yumi_i && !fifo_v));

endmodule

// File: tb/tb_bp_bpred_trace_buffer.sv
// Directed bench for bp_bpred_trace_buffer: vector table plus corner-case sequences.
module tb_bp_bpred_trace_buffer;

    localparam int EW = 27;

    logic          clk, rst_n, clear, yumi_en;
    logic [1:0]    mode, wv, corr;
    logic [8:0]    idx0, idx1;
    logic          tv, full, yumi, tv2, full2, yumi2;
    logic [EW-1:0] data, data2;
    logic [31:0]   upd, mis, drp;
    logic [3:0]    upd2, mis2, drp2;

    int checks = 0;
    int errors = 0;

    assign yumi  = yumi_en & tv;
    assign yumi2 = yumi_en & tv2;

    bp_bpred_trace_buffer dut (
        .clk_i(clk), .reset_n_i(rst_n), .mode_i(mode), .clear_i(clear),
        .w_v_i(wv), .idx_w_i({idx1, idx0}), .correct_i(corr),
        .trace_v_o(tv), .trace_data_o(data), .trace_yumi_i(yumi),
        .update_cnt_o(upd), .mispred_cnt_o(mis), .drop_cnt_o(drp), .full_o(full));

    bp_bpred_trace_buffer #(.cnt_width_p(4)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .mode_i(mode), .clear_i(clear),
        .w_v_i(wv), .idx_w_i({idx1, idx0}), .correct_i(corr),
        .trace_v_o(tv2), .trace_data_o(data2), .trace_yumi_i(yumi2),
        .update_cnt_o(upd2), .mispred_cnt_o(mis2), .drop_cnt_o(drp2), .full_o(full2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mode;
        logic [1:0]    wv;
        logic [8:0]    idx0;
        logic [8:0]    idx1;
        logic [1:0]    corr;
        int            dly;
        logic          exp_v;
        logic [EW-1:0] exp_data;
        int            exp_upd;
        int            exp_mis;
        int            exp_n;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Pops everything available within a bounded window; returns entry count and last entry.
    task automatic drain(input int max_cyc, output int n, output logic [EW-1:0] last);
        n = 0;
        last = '0;
        yumi_en = 1'b1;
        for (int k = 0; k < max_cyc; k++) begin
            if (tv) begin
                n++;
                last = data;
            end
            tick();
        end
        yumi_en = 1'b0;
    endtask

    int n;
    logic [EW-1:0] last;
    logic [EW-1:0] got[8];
    logic [EW-1:0] exp3[4];

    initial begin
        vecs[0] = '{2'd1, 2'b01, 9'h005, 9'h000, 2'b01, 10, 1'b1, {16'd10, 1'b0, 9'h005, 1'b1}, 1, 0, 1};
        vecs[1] = '{2'd2, 2'b11, 9'h033, 9'h01A, 2'b01, 3,  1'b1, {16'd3,  1'b1, 9'h01A, 1'b0}, 2, 1, 1};
        vecs[2] = '{2'd3, 2'b11, 9'h011, 9'h022, 2'b00, 0,  1'b0, 27'd0,                        2, 2, 0};
        vecs[3] = '{2'd0, 2'b11, 9'h011, 9'h022, 2'b00, 2,  1'b0, 27'd0,                        0, 0, 0};
        vecs[4] = '{2'd1, 2'b11, 9'h1FF, 9'h100, 2'b10, 7,  1'b1, {16'd7,  1'b0, 9'h1FF, 1'b0}, 2, 1, 2};
        vecs[5] = '{2'd2, 2'b10, 9'h044, 9'h055, 2'b10, 1,  1'b0, 27'd0,                        1, 0, 0};
        exp3[0] = {16'd0, 1'b0, 9'h000, 1'b1};
        exp3[1] = {16'd0, 1'b1, 9'h010, 1'b1};
        exp3[2] = {16'd1, 1'b0, 9'h001, 1'b1};
        exp3[3] = {16'd2, 1'b1, 9'h012, 1'b1};

        rst_n = 1'b0; clear = 1'b0; yumi_en = 1'b0; mode = 2'd0;
        wv = '0; corr = '0; idx0 = '0; idx1 = '0;
        #12;
        chk("reset_v", tv, 0);
        chk("reset_data", data, 0);
        chk("reset_cnts", {upd, mis, drp}, 0);
        chk("reset_full", full, 0);
        #2 rst_n = 1'b1;
        tick();

        // Single-cycle event vectors with a two-cycle capture-to-head latency.
        for (int v = 0; v < 6; v++) begin
            do_clear();
            repeat (vecs[v].dly) tick();
            mode = vecs[v].mode; wv = vecs[v].wv; corr = vecs[v].corr;
            idx0 = vecs[v].idx0; idx1 = vecs[v].idx1;
            tick();
            wv = '0;
            chk($sformatf("v%0d_latency_v", v), tv, 0);
            tick();
            chk($sformatf("v%0d_v", v), tv, vecs[v].exp_v);
            chk($sformatf("v%0d_data", v), data, vecs[v].exp_data);
            chk($sformatf("v%0d_upd", v), upd, vecs[v].exp_upd);
            chk($sformatf("v%0d_mis", v), mis, vecs[v].exp_mis);
            drain(6, n, last);
            chk($sformatf("v%0d_n", v), n, vecs[v].exp_n);
        end

        // Both channels active three cycles, consumer always ready.
        do_clear();
        mode = 2'd1; yumi_en = 1'b1; n = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 3) begin
                wv = 2'b11; corr = 2'b11; idx0 = 9'(k); idx1 = 9'(16 + k);
            end else begin
                wv = '0;
            end
            tick();
            if (tv && n < 8) begin
                got[n] = data;
                n++;
            end
        end
        yumi_en = 1'b0;
        chk("rr_count", n, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("rr_entry%0d", k), got[k], exp3[k]);
        chk("rr_drop", drp, 2);
        chk("rr_upd", upd, 6);

        // Fill to full, overflow into staging then drop, then pop+push at full.
        do_clear();
        mode = 2'd1; corr = 2'b11;
        for (int k = 0; k < 18; k++) begin
            wv = 2'b01; idx0 = 9'(k);
            tick();
        end
        for (int k = 18; k < 20; k++) begin
            wv = 2'b10; idx1 = 9'(64 + k);
            tick();
        end
        wv = '0;
        tick();
        chk("full_set", full, 1);
        chk("full_drop", drp, 2);
        chk("full_head", data, {16'd0, 1'b0, 9'h000, 1'b1});
        chk("full_upd", upd, 20);
        yumi_en = 1'b1;
        tick();
        yumi_en = 1'b0;
        chk("poppush_full", full, 1);
        chk("poppush_head", data, {16'd1, 1'b0, 9'h001, 1'b1});
        drain(40, n, last);
        chk("full_drain_n", n, 17);
        chk("full_drain_last", last, {16'd16, 1'b0, 9'h010, 1'b1});
        chk("full_drain_empty", full, 0);

        // Count-only mode saturating a 4-bit counter.
        do_clear();
        mode = 2'd3;
        for (int k = 0; k < 20; k++) begin
            wv = 2'b01; corr = 2'b00; idx0 = 9'(k);
            tick();
        end
        wv = '0;
        tick();
        tick();
        chk("sat_mis4", mis2, 15);
        chk("sat_upd4", upd2, 15);
        chk("sat_mis32", mis, 20);
        chk("sat_v", tv, 0);
        chk("sat_v4", tv2, 0);

        // clear_i wins over a simultaneous event with entries queued.
        do_clear();
        mode = 2'd1; corr = 2'b01;
        for (int k = 0; k < 5; k++) begin
            wv = 2'b01; idx0 = 9'(k);
            tick();
        end
        wv = '0;
        tick();
        chk("clr_pre_v", tv, 1);
        chk("clr_pre_upd", upd, 5);
        clear = 1'b1; wv = 2'b11;
        tick();
        clear = 1'b0; wv = '0;
        chk("clr_v", tv, 0);
        chk("clr_cnts", {upd, mis, drp}, 0);
        tick();
        tick();
        chk("clr_staging_empty", tv, 0);

        // Asynchronous reset in the middle of draining.
        for (int k = 0; k < 3; k++) begin
            wv = 2'b01; idx0 = 9'(k);
            tick();
        end
        wv = '0;
        tick();
        yumi_en = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_v", tv, 0);
        chk("areset_data", data, 0);
        chk("areset_cnts", {upd, mis, drp}, 0);
        yumi_en = 1'b0;
        #3 rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
